// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg: shared state encoding and frame constants for the instruction memory loader
package imem_loader_pkg;
  typedef enum logic [2:0] {S_IDLE, S_COUNT, S_DATA, S_CHK, S_DONE, S_ERR} state_t;
  localparam int BYTES_PER_WORD = 4;
  localparam int DEF_ADDR_W = 6;
endpackage

// File: rtl/imem_loader_if.sv
// imem_loader_if: byte stream handshake plus instruction RAM write port
interface imem_loader_if import imem_loader_pkg::*; #(parameter int ADDR_W = DEF_ADDR_W);
  logic byte_valid;
  logic [7:0] byte_data;
  logic byte_ready;
  logic we;
  logic [ADDR_W-1:0] wa;
  logic [31:0] wd;
  modport master (output byte_valid, byte_data, input byte_ready, we, wa, wd);
  modport slave (input byte_valid, byte_data, output byte_ready, we, wa, wd);
endinterface

// File: rtl/imem_loader_byte_packer.sv
// imem_loader_byte_packer: shifts stream bytes MSB-first into 32-bit words and pulses word_valid per completed word
module imem_loader_byte_packer import imem_loader_pkg::*; (
  input logic clk,
  input logic reset_n,
  input logic clr,
  input logic shift,
  input logic [7:0] din,
  output logic full,
  output logic word_valid,
  output logic [31:0] word
);
  logic [1:0] idx;
  assign full = idx == 2'(BYTES_PER_WORD - 1);
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      idx <= '0;
      word_valid <= 1'b0;
      word <= '0;
    end else begin
      word_valid <= shift && full && !clr;
      if (clr) idx <= '0;
      else if (shift) begin
        idx <= idx + 1'b1;
        word <= {word[23:0], din};
      end
    end
  end
endmodule

// File: rtl/imem_loader.sv
// imem_loader: loads a counted, checksummed byte frame into instruction RAM and releases the core on success
module imem_loader import imem_loader_pkg::*; #(
  parameter int ADDR_W = DEF_ADDR_W
) (
  input logic clk,
  input logic reset_n,
  input logic start,
  imem_loader_if.slave bus,
  output logic busy,
  output logic cpu_run,
  output logic error
);
  localparam int DEPTH = 1 << ADDR_W;
  state_t state, state_n;
  logic [ADDR_W:0] waddr;
  logic [ADDR_W-1:0] last;
  logic [7:0] sum;
  logic xfer, cnt_xfer, data_xfer, clr, full, word_valid, bad_count;
  logic [31:0] word;
  assign busy = state inside {S_COUNT, S_DATA, S_CHK};
  assign cpu_run = state == S_DONE;
  assign error = state == S_ERR;
  assign bus.byte_ready = busy;
  assign bus.we = word_valid;
  assign bus.wa = waddr[ADDR_W-1:0];
  assign bus.wd = word;
  assign xfer = bus.byte_valid && bus.byte_ready && !start;
  assign cnt_xfer = xfer && state == S_COUNT;
  assign data_xfer = xfer && state == S_DATA;
  assign clr = start || cnt_xfer;
  assign bad_count = bus.byte_data == 8'd0 || 32'(bus.byte_data) > DEPTH;
  imem_loader_byte_packer u_packer (
    .clk(clk),
    .reset_n(reset_n),
    .clr(clr),
    .shift(data_xfer),
    .din(bus.byte_data),
    .full(full),
    .word_valid(word_valid),
    .word(word)
  );
  always_ff @(posedge clk) begin
    if (!reset_n) state <= S_IDLE;
    else state <= state_n;
  end
  always_comb begin
    state_n = state;
    if (start) state_n = S_COUNT;
    else if (cnt_xfer) state_n = bad_count ? S_ERR : S_DATA;
    else if (data_xfer && full && waddr == {1'b0, last}) state_n = S_CHK;
    else if (xfer && state == S_CHK) state_n = bus.byte_data == sum ? S_DONE : S_ERR;
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      waddr <= '0;
      last <= '0;
      sum <= '0;
    end else begin
      if (clr) begin
        waddr <= '0;
        sum <= '0;
      end else begin
        if (word_valid) waddr <= waddr + 1'b1;
        if (data_xfer) sum <= sum + bus.byte_data;
      end
      if (cnt_xfer) last <= ADDR_W'(bus.byte_data - 8'd1);
    end
  end
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: table-driven and randomized frame checks for imem_loader against a frame-level model
module tb_imem_loader;
  import imem_loader_pkg::*;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic start = 1'b0;
  logic busy, cpu_run, error;
  int total = 0;
  int bad = 0;
  logic [5:0] wa_q[$];
  logic [31:0] wd_q[$];
  logic [31:0] fw[$];
  imem_loader_if #(6) bus ();
  imem_loader #(.ADDR_W(6)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .start(start),
    .bus(bus.slave),
    .busy(busy),
    .cpu_run(cpu_run),
    .error(error)
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (reset_n && bus.we) begin
      wa_q.push_back(bus.wa);
      wd_q.push_back(bus.wd);
    end
  end
  typedef struct {
    logic [7:0] cnt;
    logic [31:0] w0;
    logic [31:0] w1;
    logic [7:0] chk;
    bit gaps;
    bit exp_run;
    bit exp_err;
    int exp_nw;
  } vec_t;
  vec_t vecs[6];
  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", nm, act, exp);
    end
  endtask
  function automatic logic [63:0] outs();
    return 64'({bus.byte_ready, bus.we, bus.wa, bus.wd, busy, cpu_run, error});
  endfunction
  function automatic logic [7:0] model_sum();
    int s = 0;
    foreach (fw[i]) for (int b = 0; b < 4; b++) s += int'((fw[i] >> (8 * b)) & 32'hff);
    return 8'(s % 256);
  endfunction
  task automatic do_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("start_ready_busy", {62'd0, bus.byte_ready, busy}, 64'd3);
    check("start_clears_flags", {62'd0, cpu_run, error}, 64'd0);
  endtask
  task automatic send(input logic [7:0] b, input bit gaps);
    int t = 0;
    if (gaps && $urandom_range(0, 1) == 1) repeat ($urandom_range(1, 3)) @(negedge clk);
    bus.byte_valid = 1'b1;
    bus.byte_data = b;
    while (!bus.byte_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!bus.byte_ready) begin
      check("send_timeout", 64'd0, 64'd1);
      bus.byte_valid = 1'b0;
      return;
    end
    @(negedge clk);
    bus.byte_valid = 1'b0;
  endtask
  task automatic send_words(input bit gaps);
    foreach (fw[i]) for (int b = 3; b >= 0; b--) send(fw[i][8*b +: 8], gaps);
  endtask
  task automatic frame(input string nm, input logic [7:0] cnt, input logic [7:0] chk, input bit gaps,
                       input bit exp_run, input bit exp_err, input int exp_nw);
    wa_q.delete();
    wd_q.delete();
    do_start();
    send(cnt, gaps);
    if (cnt != 8'd0 && cnt <= 8'd64) begin
      send_words(gaps);
      send(chk, gaps);
    end
    check({nm, "_nwrites"}, 64'(wa_q.size()), 64'(exp_nw));
    for (int i = 0; i < exp_nw && i < wa_q.size(); i++) begin
      check({nm, "_wa"}, 64'(wa_q[i]), 64'(i));
      check({nm, "_wd"}, 64'(wd_q[i]), 64'(fw[i]));
    end
    check({nm, "_run_err"}, {62'd0, cpu_run, error}, {62'd0, exp_run, exp_err});
    check({nm, "_idle_port"}, {62'd0, bus.byte_ready, busy}, 64'd0);
  endtask
  initial begin
    bus.byte_valid = 1'b0;
    bus.byte_data = 8'h00;
    vecs[0] = '{8'h02, 32'h82102001, 32'h01000000, 8'hB4, 1'b0, 1'b1, 1'b0, 2};
    vecs[1] = '{8'h02, 32'h82102001, 32'h01000000, 8'hB5, 1'b0, 1'b0, 1'b1, 2};
    vecs[2] = '{8'h02, 32'h82102001, 32'h01000000, 8'hB4, 1'b1, 1'b1, 1'b0, 2};
    vecs[3] = '{8'h00, 32'h0, 32'h0, 8'h00, 1'b0, 1'b0, 1'b1, 0};
    vecs[4] = '{8'h41, 32'h0, 32'h0, 8'h00, 1'b0, 1'b0, 1'b1, 0};
    vecs[5] = '{8'h01, 32'hDEADBEEF, 32'h0, 8'h38, 1'b1, 1'b1, 1'b0, 1};
    repeat (3) @(negedge clk);
    check("reset_outputs", outs(), 64'd0);
    reset_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check("idle_outputs", outs(), 64'd0);
    end
    check("idle_no_we", 64'(wa_q.size()), 64'd0);
    foreach (vecs[v]) begin
      fw.delete();
      if (vecs[v].cnt >= 8'd1 && vecs[v].cnt <= 8'd2) fw.push_back(vecs[v].w0);
      if (vecs[v].cnt == 8'd2) fw.push_back(vecs[v].w1);
      frame($sformatf("vec%0d", v), vecs[v].cnt, vecs[v].chk, vecs[v].gaps,
            vecs[v].exp_run, vecs[v].exp_err, vecs[v].exp_nw);
    end
    wa_q.delete();
    wd_q.delete();
    do_start();
    send(8'h02, 1'b0);
    fw = '{32'h11223344};
    send_words(1'b0);
    send(8'h55, 1'b0);
    bus.byte_valid = 1'b1;
    bus.byte_data = 8'hFF;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    bus.byte_valid = 1'b0;
    check("abort_restart", {62'd0, bus.byte_ready, busy}, 64'd3);
    send(8'h02, 1'b0);
    fw = '{32'h82102001, 32'h01000000};
    send_words(1'b0);
    send(8'hB4, 1'b0);
    check("abort_nwrites", 64'(wa_q.size()), 64'd3);
    if (wa_q.size() == 3) begin
      check("abort_old_word", {26'd0, wa_q[0], wd_q[0]}, {26'd0, 6'd0, 32'h11223344});
      check("abort_w0", {26'd0, wa_q[1], wd_q[1]}, {26'd0, 6'd0, 32'h82102001});
      check("abort_w1", {26'd0, wa_q[2], wd_q[2]}, {26'd0, 6'd1, 32'h01000000});
    end
    check("abort_run", {62'd0, cpu_run, error}, 64'd2);
    do_start();
    send(8'h02, 1'b0);
    send(8'h12, 1'b0);
    send(8'h34, 1'b0);
    check("midword_wd_live", 64'(bus.wd != 32'd0), 64'd1);
    reset_n = 1'b0;
    start = 1'b1;
    bus.byte_valid = 1'b1;
    @(posedge clk);
    #1;
    check("midword_reset", outs(), 64'd0);
    start = 1'b0;
    bus.byte_valid = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("after_reset_idle", outs(), 64'd0);
    for (int it = 0; it < 6; it++) begin
      int n;
      bit good;
      logic [7:0] s;
      n = (it == 0) ? 64 : int'($urandom_range(1, 4));
      fw.delete();
      for (int i = 0; i < n; i++) fw.push_back($urandom);
      s = model_sum();
      good = (it == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      if (!good) s = s + 8'($urandom_range(1, 255));
      frame($sformatf("rnd%0d", it), 8'(n), s, 1'($urandom_range(0, 1)), good, !good, n);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
